// File: rtl/seven_seg_mux_n.sv
// ---------------------------------------------------------------------------
// seven_seg_mux_n
//   N-digit time-multiplexed seven-segment driver. A refresh counter divides
//   clk so that each digit is shown for DIV+1 cycles, round-robin over DIGITS
//   digits. On every digit switch the pattern and one-hot anode of the next
//   digit are registered, so input changes between switches never glitch the
//   pins.
//
//   Optional feature (macro SEVSEG_DIMMING_EN): adds a 4-bit brightness input.
//   The anode is gated off for the tail of each digit slot (PWM dimming).
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous reset, active-high
//   en        in   refresh enable; low freezes counter and outputs
//   segs_in   in   packed patterns, digit k at [7k+6:7k]
//   digit_en  in   per-digit enable, 0 blanks that digit
//   bright    in   brightness 0..15 (only with SEVSEG_DIMMING_EN)
//   segment   out  registered segment pattern of the displayed digit
//   anode     out  one-hot digit select, all zero when blanked
//   sel       out  index of the displayed digit
//   tick      out  one-cycle pulse in the cycle after a digit switch
//   frame     out  pulse coincident with tick when sel wraps to 0
// ---------------------------------------------------------------------------
module seven_seg_mux_n #(
  parameter int DIGITS = 4,
  parameter int DIV    = 7500,
  parameter int CBITS  = 13,
  parameter int SELW   = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7*DIGITS-1:0]   segs_in,
  input  logic [DIGITS-1:0]     digit_en,
`ifdef SEVSEG_DIMMING_EN
  input  logic [3:0]            bright,
`endif
  output logic [6:0]            segment,
  output logic [DIGITS-1:0]     anode,
  output logic [SELW-1:0]       sel,
  output logic                  tick,
  output logic                  frame
);

  localparam int PERIOD = DIV + 1;

  function automatic logic [6:0] pick_seg(input logic [7*DIGITS-1:0] s,
                                          input logic [DIGITS-1:0]   de,
                                          input logic [SELW-1:0]     idx);
    return de[idx] ? s[7*idx +: 7] : 7'b0;
  endfunction

  function automatic logic [DIGITS-1:0] pick_anode(input logic [DIGITS-1:0] de,
                                                   input logic [SELW-1:0]   idx);
    return de[idx] ? (DIGITS'(1) << idx) : '0;
  endfunction

  logic [CBITS-1:0]  cnt_p0;
  logic [SELW-1:0]   sel_p0;
  logic [6:0]        seg_p0;
  logic [DIGITS-1:0] anode_p0;
  logic              tick_p0;
  logic              frame_p0;

  logic              at_end;
  logic [SELW-1:0]   nsel;

  assign at_end = (cnt_p0 == CBITS'(DIV));
  assign nsel   = (sel_p0 == SELW'(DIGITS - 1)) ? '0 : sel_p0 + SELW'(1);

  // Stage p0: refresh counter, digit pointer and registered pin values
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0   <= '0;
      sel_p0   <= SELW'(DIGITS - 1);
      seg_p0   <= '0;
      anode_p0 <= '0;
      tick_p0  <= 1'b0;
      frame_p0 <= 1'b0;
    end else if (en) begin
      if (at_end) begin
        cnt_p0   <= '0;
        sel_p0   <= nsel;
        seg_p0   <= pick_seg(segs_in, digit_en, nsel);
        anode_p0 <= pick_anode(digit_en, nsel);
        tick_p0  <= 1'b1;
        frame_p0 <= (nsel == '0);
      end else begin
        cnt_p0   <= cnt_p0 + CBITS'(1);
        tick_p0  <= 1'b0;
        frame_p0 <= 1'b0;
      end
    end else begin
      tick_p0  <= 1'b0;
      frame_p0 <= 1'b0;
    end
  end

`ifdef SEVSEG_DIMMING_EN
  // on_len can equal 2**CBITS when DIV is at its maximum, hence CBITS+1 bits.
  function automatic logic [CBITS:0] on_len_calc(input logic [3:0] b);
    logic [CBITS+4:0] prod;
    prod = (CBITS+5)'(PERIOD) * ((CBITS+5)'(b) + (CBITS+5)'(1));
    return prod[CBITS+4:4];
  endfunction

  logic [CBITS:0] on_len_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      on_len_p0 <= (CBITS+1)'(PERIOD);
    end else if (en && at_end) begin
      on_len_p0 <= on_len_calc(bright);
    end
  end

  // Gating uses the current counter value, so the anode turns off mid-slot.
  assign anode = anode_p0 & {DIGITS{({1'b0, cnt_p0} < on_len_p0)}};
`else
  assign anode = anode_p0;
`endif

  assign segment = seg_p0;
  assign sel     = sel_p0;
  assign tick    = tick_p0;
  assign frame   = frame_p0;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_mux_n
//   Directed bench for seven_seg_mux_n with DIGITS=4, DIV=3. A vector table
//   covers the first frames after reset and a blanked digit; hand-written
//   sequences cover mid-slot input changes, en hold, reset mid-digit and,
//   when SEVSEG_DIMMING_EN is defined, brightness gating.
// ---------------------------------------------------------------------------
module tb_seven_seg_mux_n;

  localparam int DIGITS = 4;
  localparam int DIV    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [27:0] segs_in;
  logic [3:0]  digit_en;
`ifdef SEVSEG_DIMMING_EN
  logic [3:0]  bright;
`endif
  logic [6:0]  segment;
  logic [3:0]  anode;
  logic [1:0]  sel;
  logic        tick;
  logic        frame;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_mux_n #(.DIGITS(DIGITS), .DIV(DIV), .CBITS(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .segs_in  (segs_in),
    .digit_en (digit_en),
`ifdef SEVSEG_DIMMING_EN
    .bright   (bright),
`endif
    .segment  (segment),
    .anode    (anode),
    .sel      (sel),
    .tick     (tick),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] den;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] sel;
    logic       tick;
    logic       frame;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [6:0] s, input logic [3:0] a,
                         input logic [1:0] sl, input logic t, input logic f);
    chk({name, ".segment"}, 32'(segment), 32'(s));
    chk({name, ".anode"},   32'(anode),   32'(a));
    chk({name, ".sel"},     32'(sel),     32'(sl));
    chk({name, ".tick"},    32'(tick),    32'(t));
    chk({name, ".frame"},   32'(frame),   32'(f));
    chk({name, ".onehot"},  32'($onehot0(anode)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [27:0] SEGS0 = {7'h4F, 7'h5B, 7'h06, 7'h3F};

  initial begin
    // index = edge number after reset release minus one
    vecs[0]  = '{4'hF, 7'h00, 4'h0, 2'd3, 1'b0, 1'b0};
    vecs[1]  = '{4'hF, 7'h00, 4'h0, 2'd3, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 7'h00, 4'h0, 2'd3, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 7'h3F, 4'h1, 2'd0, 1'b1, 1'b1};
    vecs[4]  = '{4'hF, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[5]  = '{4'hF, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'hF, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[7]  = '{4'hF, 7'h06, 4'h2, 2'd1, 1'b1, 1'b0};
    vecs[8]  = '{4'hF, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[10] = '{4'hF, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[11] = '{4'hF, 7'h5B, 4'h4, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{4'hF, 7'h5B, 4'h4, 2'd2, 1'b0, 1'b0};
    vecs[13] = '{4'hF, 7'h5B, 4'h4, 2'd2, 1'b0, 1'b0};
    vecs[14] = '{4'hF, 7'h5B, 4'h4, 2'd2, 1'b0, 1'b0};
    vecs[15] = '{4'hF, 7'h4F, 4'h8, 2'd3, 1'b1, 1'b0};
    vecs[16] = '{4'hF, 7'h4F, 4'h8, 2'd3, 1'b0, 1'b0};
    vecs[17] = '{4'hF, 7'h4F, 4'h8, 2'd3, 1'b0, 1'b0};
    vecs[18] = '{4'hF, 7'h4F, 4'h8, 2'd3, 1'b0, 1'b0};
    vecs[19] = '{4'hF, 7'h3F, 4'h1, 2'd0, 1'b1, 1'b1};
    vecs[20] = '{4'hB, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{4'hB, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[22] = '{4'hB, 7'h3F, 4'h1, 2'd0, 1'b0, 1'b0};
    vecs[23] = '{4'hB, 7'h06, 4'h2, 2'd1, 1'b1, 1'b0};
    vecs[24] = '{4'hB, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[25] = '{4'hB, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[26] = '{4'hB, 7'h06, 4'h2, 2'd1, 1'b0, 1'b0};
    vecs[27] = '{4'hB, 7'h00, 4'h0, 2'd2, 1'b1, 1'b0};

    rst      = 1'b1;
    en       = 1'b1;
    digit_en = 4'hF;
    segs_in  = SEGS0;
`ifdef SEVSEG_DIMMING_EN
    bright   = 4'd15;
`endif
    step();
    step();
    chk_all("reset", 7'h00, 4'h0, 2'd3, 1'b0, 1'b0);

    rst = 1'b0;
    for (int i = 0; i < 28; i++) begin
      digit_en = vecs[i].den;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].seg, vecs[i].an, vecs[i].sel,
              vecs[i].tick, vecs[i].frame);
    end

    // Now cnt=0, sel=2 (blanked). Change inputs at cnt=1; they must not show
    // until the switch into digit 3.
    digit_en = 4'hF;
    step();
    segs_in = {7'h71, 7'h5B, 7'h06, 7'h3F};
    step();
    chk_all("midslot_c2", 7'h00, 4'h0, 2'd2, 1'b0, 1'b0);
    step();
    chk_all("midslot_c3", 7'h00, 4'h0, 2'd2, 1'b0, 1'b0);
    step();
    chk_all("midslot_sw", 7'h71, 4'h8, 2'd3, 1'b1, 1'b0);

    // Hold en low at cnt=2 for 10 cycles.
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("hold%0d", i), 7'h71, 4'h8, 2'd3, 1'b0, 1'b0);
    end
    en = 1'b1;
    segs_in = SEGS0;
    step();
    chk_all("resume1", 7'h71, 4'h8, 2'd3, 1'b0, 1'b0);
    step();
    chk_all("resume2", 7'h3F, 4'h1, 2'd0, 1'b1, 1'b1);

    // Advance to sel=3, cnt=2, then pulse reset for one cycle.
    for (int i = 0; i < 14; i++) step();
    chk_all("pre_rst", 7'h4F, 4'h8, 2'd3, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    chk_all("mid_rst", 7'h00, 4'h0, 2'd3, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("post_rst%0d", i), 7'h00, 4'h0, 2'd3, 1'b0, 1'b0);
    end
    step();
    chk_all("post_rst_sw", 7'h3F, 4'h1, 2'd0, 1'b1, 1'b1);

`ifdef SEVSEG_DIMMING_EN
    // bright=7 -> on_len=(4*8)>>4=2: anode on for cnt 0..1 only.
    bright = 4'd7;
    for (int i = 0; i < 4; i++) step();
    chk("dim7_c0", 32'(anode), 32'h2);
    step();
    chk("dim7_c1", 32'(anode), 32'h2);
    step();
    chk("dim7_c2", 32'(anode), 32'h0);
    step();
    chk("dim7_c3", 32'(anode), 32'h0);
    chk("dim7_seg", 32'(segment), 32'h06);
    // bright=15 -> on_len=4: on for the whole slot.
    bright = 4'd15;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("dim15_c%0d", i), 32'(anode), 32'h4);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
